clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Timekeeping and time-setting controller for the six-digit HH:MM:SS segment display.
- Holds the six BCD digit registers (hours2/hours1/minutes2/minutes1/seconds2/seconds1) that drive the scanning display driver.
- Advances the time at 1 Hz and runs a key-driven set-mode FSM that selects one field, increments it and flags its digits for blinking.
- Sits between the debounced key block and the display scanner.

Parameters:
- TICK_CNT, 50_000_000, CLK_50M cycles per 1 s time tick.
- BLINK_CNT, 12_500_000, cycles per blink-phase toggle (250 ms at 50 MHz, i.e. 2 Hz blink).

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- key_mode  in  1  debounced single-cycle pulse: advance set-mode state.
- key_inc  in  1  debounced single-cycle pulse: increment selected field.
- hours2_data  out  4  hours tens BCD (0-2).
- hours1_data  out  4  hours units BCD (0-9).
- minutes2_data  out  4  minutes tens BCD (0-5).
- minutes1_data  out  4  minutes units BCD (0-9).
- seconds2_data  out  4  seconds tens BCD (0-5).
- seconds1_data  out  4  seconds units BCD (0-9).
- blank_mask  out  6  1 = blank digit; bit0 hours2 … bit5 seconds1, matching SEG1..SEG6.
- set_state  out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.

Behaviour:
- Reset:
  - Async on RST_N low.
  - All digits 0 (00:00:00), set_state RUN, blank_mask 0.
  - Prescaler, blink counter and blink phase all 0.
- Outputs: all registered; digits change on the edge after the qualifying event.
- Prescaler:
  - Counts 0..TICK_CNT-1 in RUN only.
  - At TICK_CNT-1 it wraps to 0 and issues a tick. First tick is TICK_CNT cycles after reset release.
  - Held at 0 in every SET state.
- RUN tick: seconds +1 BCD.
  - Seconds 59→00 carries into minutes; minutes 59→00 carries into hours.
  - Hours 23→00, so 23:59:59 → 00:00:00 in one edge.
  - Units wrap 9→0 with a tens increment; no digit ever holds a non-BCD value.
- FSM on key_mode: RUN→SET_HR→SET_MIN→SET_SEC→RUN.
- key_inc in RUN: ignored.
- key_inc in a SET state:
  - SET_HR: hours +1, 23→00.
  - SET_MIN: minutes +1, 59→00, no carry into hours.
  - SET_SEC: seconds forced to 00.
- key_mode and key_inc in the same cycle: mode wins; inc is dropped.
- Every cycle the input is high counts as a separate event. Upstream must deliver single-cycle pulses.
- Leaving SET_SEC to RUN: prescaler starts at 0, so the next tick comes a full TICK_CNT cycles later.
- Blink:
  - In SET states the blink counter counts 0..BLINK_CNT-1 and toggles the phase at wrap.
  - Phase 1 = blank.
  - Counter and phase clear to 0 (visible) on every state change and on every accepted key_inc, so the field is shown immediately after an edit.
- blank_mask:
  - RUN: 000000.
  - SET_HR: 000011 when phase=1.
  - SET_MIN: 001100 when phase=1.
  - SET_SEC: 110000 when phase=1.
  - Otherwise 0.
- Reset mid-setting: returns to RUN at 00:00:00 and discards partial edits.

Test Plan (TICK_CNT=10, BLINK_CNT=4):
- Reset release, no keys → seconds1_data 0 until cycle 10, then 1. After 600 cycles the display reads 00:01:00.
- Force to 23:59:58 via SET_HR/SET_MIN/SET_SEC inc sequences, then RUN → 23:59:59 after one tick, 00:00:00 after the next, with all six digits changing on the same edge.
- Four key_mode pulses:
  - set_state steps 1,2,3,0.
  - Time frozen during SET states.
  - After the return to RUN, the next seconds increment occurs exactly 10 cycles later.
- SET_MIN, minutes 59, key_inc → minutes 00, hours unchanged.
- SET_HR, hours 23, key_inc → 00.
- SET_SEC at seconds 37, key_inc → 00.
- SET_HR idle → blank_mask alternates 000000/000011 every 4 cycles starting visible. A key_inc mid-blank forces 000000 on the next edge and restarts the 4-cycle count.
- key_mode and key_inc high in the same cycle in SET_HR → state becomes SET_MIN and hours unchanged.
- RST_N pulsed low in SET_MIN at 12:34:56 → immediately RUN, 00:00:00, blank_mask 0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS timekeeping with 1 Hz advance and a key-driven field-setting FSM.
// Drives six BCD digits plus a per-digit blank mask for the display scanner.
module clock_set_ctrl #(
    parameter int unsigned TICK_CNT  = 50_000_000,
    parameter int unsigned BLINK_CNT = 12_500_000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] hours2_data,
    output logic [3:0] hours1_data,
    output logic [3:0] minutes2_data,
    output logic [3:0] minutes1_data,
    output logic [3:0] seconds2_data,
    output logic [3:0] seconds1_data,
    output logic [5:0] blank_mask,
    output logic [1:0] set_state
);

    localparam int unsigned PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam int unsigned BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CNT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_SET_HR  = 2'd1;
    localparam logic [1:0] S_SET_MIN = 2'd2;
    localparam logic [1:0] S_SET_SEC = 2'd3;

    logic [1:0]    state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [BW-1:0] blink_cnt, blink_next;
    logic          phase, phase_next;
    logic [7:0]    hr, hr_next, mn, mn_next, sc, sc_next;
    logic [5:0]    mask_next;
    logic          tick, inc_ok;

    // Two-digit BCD increment that wraps to 00 after reaching max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        if (val == max)
            return 8'h00;
        else if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        else
            return {val[7:4], val[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_next = state;
        presc_next = presc;
        blink_next = blink_cnt;
        phase_next = phase;
        hr_next    = hr;
        mn_next    = mn;
        sc_next    = sc;
        mask_next  = 6'b000000;
        tick       = 1'b0;
        inc_ok     = key_inc && !key_mode && (state != S_RUN);

        if (key_mode) begin
            case (state)
                S_RUN:     state_next = S_SET_HR;
                S_SET_HR:  state_next = S_SET_MIN;
                S_SET_MIN: state_next = S_SET_SEC;
                default:   state_next = S_RUN;
            endcase
        end

        if (state == S_RUN) begin
            if (presc == PRESC_LAST) begin
                presc_next = '0;
                tick       = 1'b1;
            end else begin
                presc_next = presc + PW'(1);
            end
        end else begin
            presc_next = '0;
        end

        // Ripple carry seconds -> minutes -> hours on the tick edge.
        if (tick) begin
            sc_next = bcd_inc(sc, 8'h59);
            if (sc == 8'h59) begin
                mn_next = bcd_inc(mn, 8'h59);
                if (mn == 8'h59)
                    hr_next = bcd_inc(hr, 8'h23);
            end
        end

        if (inc_ok) begin
            case (state)
                S_SET_HR:  hr_next = bcd_inc(hr, 8'h23);
                S_SET_MIN: mn_next = bcd_inc(mn, 8'h59);
                S_SET_SEC: sc_next = 8'h00;
                default:   ;
            endcase
        end

        // Restart visible phase on any state change or edit.
        if ((state_next != state) || inc_ok || (state == S_RUN)) begin
            blink_next = '0;
            phase_next = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_next = '0;
            phase_next = ~phase;
        end else begin
            blink_next = blink_cnt + BW'(1);
        end

        if (phase_next) begin
            case (state_next)
                S_SET_HR:  mask_next = 6'b000011;
                S_SET_MIN: mask_next = 6'b001100;
                S_SET_SEC: mask_next = 6'b110000;
                default:   mask_next = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_RUN;
            presc      <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            hr         <= 8'h00;
            mn         <= 8'h00;
            sc         <= 8'h00;
            blank_mask <= 6'b000000;
        end else begin
            state      <= state_next;
            presc      <= presc_next;
            blink_cnt  <= blink_next;
            phase      <= phase_next;
            hr         <= hr_next;
            mn         <= mn_next;
            sc         <= sc_next;
            blank_mask <= mask_next;
        end
    end

    assign set_state     = state;
    assign hours2_data   = hr[7:4];
    assign hours1_data   = hr[3:0];
    assign minutes2_data = mn[7:4];
    assign minutes1_data = mn[3:0];
    assign seconds2_data = sc[7:4];
    assign seconds1_data = sc[3:0];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: time-of-day reference model plus literal scenario checks.
module tb_clock_set_ctrl;

    localparam int TICK  = 10;
    localparam int BLINK = 4;

    logic       CLK_50M = 1'b0;
    logic       RST_N   = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc  = 1'b0;
    logic [3:0] hours2_data, hours1_data, minutes2_data, minutes1_data;
    logic [3:0] seconds2_data, seconds1_data;
    logic [5:0] blank_mask;
    logic [1:0] set_state;
    logic [23:0] dut_time;

    int tests  = 0;
    int failed = 0;

    // Reference model: time as seconds-of-day, mode index, cycle counters.
    int m_secs, m_state, m_run, m_k;

    clock_set_ctrl #(.TICK_CNT(TICK), .BLINK_CNT(BLINK)) dut (
        .CLK_50M(CLK_50M), .RST_N(RST_N), .key_mode(key_mode), .key_inc(key_inc),
        .hours2_data(hours2_data), .hours1_data(hours1_data),
        .minutes2_data(minutes2_data), .minutes1_data(minutes1_data),
        .seconds2_data(seconds2_data), .seconds1_data(seconds1_data),
        .blank_mask(blank_mask), .set_state(set_state)
    );

    always #5 CLK_50M = ~CLK_50M;

    assign dut_time = {hours2_data, hours1_data, minutes2_data, minutes1_data,
                       seconds2_data, seconds1_data};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_state = 0; m_run = 0; m_k = 0;
    endtask

    task automatic model_step(input bit m, input bit i);
        int  h, mi, s, nst;
        bit  tick, acc;
        h    = m_secs / 3600;
        mi   = (m_secs / 60) % 60;
        s    = m_secs % 60;
        tick = (m_state == 0) && (m_run == TICK - 1);
        acc  = (m_state != 0) && i && !m;
        nst  = m ? (m_state + 1) % 4 : m_state;
        m_run = (m_state == 0 && !tick) ? m_run + 1 : 0;
        if (tick) m_secs = (m_secs + 1) % 86400;
        if (acc) begin
            if (m_state == 1) h = (h + 1) % 24;
            if (m_state == 2) mi = (mi + 1) % 60;
            if (m_state == 3) s = 0;
            m_secs = h * 3600 + mi * 60 + s;
        end
        if (nst != m_state || acc || m_state == 0) m_k = 0;
        else m_k = (m_k + 1) % (2 * BLINK);
        m_state = nst;
    endtask

    function automatic logic [23:0] model_time();
        int h, mi, s;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [5:0] model_mask();
        if (m_state == 0 || ((m_k / BLINK) % 2) == 0) return 6'b000000;
        if (m_state == 1) return 6'b000011;
        if (m_state == 2) return 6'b001100;
        return 6'b110000;
    endfunction

    task automatic compare_model();
        check("time", 32'(dut_time), 32'(model_time()));
        check("state", 32'(set_state), 32'(m_state));
        check("mask", 32'(blank_mask), 32'(model_mask()));
    endtask

    // One clock: drive keys, advance model at the edge, compare on the falling edge.
    task automatic cycle(input bit m, input bit i);
        key_mode = m;
        key_inc  = i;
        @(posedge CLK_50M);
        model_step(m, i);
        @(negedge CLK_50M);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        RST_N    = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK_50M);
        RST_N = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_time", 32'(dut_time), 32'h000000);
        check("rst_state", 32'(set_state), 32'd0);
        check("rst_mask", 32'(blank_mask), 32'd0);

        // Free run from reset: first tick on cycle 10, one minute at 600.
        idle(9);
        check("tick_c9", 32'(dut_time), 32'h000000);
        idle(1);
        check("tick_c10", 32'(dut_time), 32'h000001);
        idle(590);
        check("one_min", 32'(dut_time), 32'h000100);

        // Set 23:59:00 with hour and minute wrap checks along the way.
        cycle(1'b1, 1'b0);
        check("st_hr", 32'(set_state), 32'd1);
        incs(23);
        check("hr23", 32'(dut_time), 32'h230100);
        incs(1);
        check("hr_wrap", 32'(dut_time), 32'h000100);
        incs(23);
        cycle(1'b1, 1'b0);
        incs(58);
        check("min59", 32'(dut_time), 32'h235900);
        incs(1);
        check("min_wrap", 32'(dut_time), 32'h230000);
        incs(59);
        cycle(1'b1, 1'b0);
        incs(1);
        cycle(1'b1, 1'b0);
        check("back_run", 32'(set_state), 32'd0);
        idle(579);
        check("t235957", 32'(dut_time), 32'h235957);
        idle(1);
        check("t235958", 32'(dut_time), 32'h235958);
        idle(10);
        check("t235959", 32'(dut_time), 32'h235959);
        idle(9);
        check("pre_wrap", 32'(dut_time), 32'h235959);
        idle(1);
        check("day_wrap", 32'(dut_time), 32'h000000);

        // Mode cycle freezes time; prescaler restarts on return to RUN.
        cycle(1'b1, 1'b0);
        idle(15);
        check("frozen", 32'(dut_time), 32'h000000);
        cycle(1'b1, 1'b0);
        check("st_min", 32'(set_state), 32'd2);
        cycle(1'b1, 1'b0);
        check("st_sec", 32'(set_state), 32'd3);
        cycle(1'b1, 1'b0);
        check("st_run", 32'(set_state), 32'd0);
        idle(9);
        check("restart_c9", 32'(dut_time), 32'h000000);
        idle(1);
        check("restart_c10", 32'(dut_time), 32'h000001);

        // Seconds clear in SET_SEC.
        do_reset();
        idle(370);
        check("t37", 32'(dut_time), 32'h000037);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        check("sec_state", 32'(set_state), 32'd3);
        incs(1);
        check("sec_clear", 32'(dut_time), 32'h000000);

        // Blink phase in SET_HR and restart on edit.
        do_reset();
        cycle(1'b1, 1'b0);
        check("blink_entry", 32'(blank_mask), 32'h00);
        idle(3);
        check("blink_vis3", 32'(blank_mask), 32'h00);
        idle(1);
        check("blink_blank", 32'(blank_mask), 32'h03);
        idle(3);
        check("blink_blank7", 32'(blank_mask), 32'h03);
        idle(1);
        check("blink_vis8", 32'(blank_mask), 32'h00);
        idle(5);
        check("blink_blank13", 32'(blank_mask), 32'h03);
        incs(1);
        check("edit_vis", 32'(blank_mask), 32'h00);
        check("edit_hr", 32'(dut_time), 32'h010000);
        idle(3);
        check("edit_vis3", 32'(blank_mask), 32'h00);
        idle(1);
        check("edit_blank", 32'(blank_mask), 32'h03);

        // Mode beats inc in the same cycle.
        cycle(1'b1, 1'b1);
        check("both_state", 32'(set_state), 32'd2);
        check("both_hr", 32'(dut_time), 32'h010000);

        // Async reset in the middle of setting 12:34:56.
        do_reset();
        cycle(1'b1, 1'b0);
        incs(12);
        cycle(1'b1, 1'b0);
        incs(34);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        idle(560);
        check("t123456", 32'(dut_time), 32'h123456);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("pre_rst_state", 32'(set_state), 32'd2);
        #2 RST_N = 1'b0;
        #1;
        check("arst_time", 32'(dut_time), 32'h000000);
        check("arst_state", 32'(set_state), 32'd0);
        check("arst_mask", 32'(blank_mask), 32'd0);
        do_reset();

        // Random key traffic against the model.
        for (int c = 0; c < 3000; c++)
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
